// File: rtl/frame_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_stream_arbiter
// Function : Frame-atomic round-robin merge of NUM_CH framed streams.
//            Define FRAME_STREAM_ARBITER_CHECK_EN for header/footer checking.
// Revision : 1.0
// ============================================================================
module frame_stream_arbiter #(
  parameter int         NUM_CH        = 4,
  parameter int         DATA_WIDTH    = 64,
  parameter int         LEN_WIDTH     = 10,
  parameter int         MAX_FRAME_LEN = 400,
  parameter logic [7:0] HEADER_ID     = 8'hFF,
  parameter logic [7:0] FOOTER_ID     = 8'h0F
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_CH-1:0]            CH_VALID,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CH_DATA,
  output logic [NUM_CH-1:0]            CH_READY,
  output logic                         M_VALID,
  output logic [DATA_WIDTH-1:0]        M_DATA,
  output logic                         M_LAST,
  output logic [$clog2(NUM_CH)-1:0]    M_CH,
  input  logic                         M_READY,
  output logic [31:0]                  FRAME_CNT,
  output logic [15:0]                  ERR_CNT
);

  localparam int          CH_W     = $clog2(NUM_CH);
  localparam logic [31:0] c_max_len = MAX_FRAME_LEN;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_BODY   = 2'd2;
  localparam logic [1:0] S_FOOTER = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [CH_W-1:0]       r_grant;
  logic [CH_W-1:0]       r_rr_ptr;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic [CH_W-1:0]       r_m_ch;
  logic [31:0]           r_frame_cnt;

  logic                  w_any_req;
  logic [CH_W-1:0]       w_pick;
  logic [DATA_WIDTH-1:0] w_in_data;
  logic                  w_slot;
  logic                  w_xfer;
  logic                  w_load;
  logic                  w_hdr_drop;
  logic [LEN_WIDTH-1:0]  w_len_raw;
  logic                  w_len_over;
  logic [LEN_WIDTH-1:0]  w_len;

  assign w_any_req  = |CH_VALID;
  assign w_slot     = (r_state != S_IDLE) && (!r_m_valid || M_READY);
  assign w_xfer     = w_slot && CH_VALID[r_grant];
  assign w_load     = w_xfer && !w_hdr_drop;
  assign w_len_raw  = w_in_data[LEN_WIDTH-1:0];
  assign w_len_over = 32'(w_len_raw) > c_max_len;
  assign w_len      = w_len_over ? c_max_len[LEN_WIDTH-1:0] : w_len_raw;

  // First requester strictly after the last served channel, cyclically
  always_comb begin
    logic [CH_W-1:0] cand;
    w_pick = '0;
    cand   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
      if (CH_VALID[cand]) w_pick = cand;
    end
  end

  always_comb begin
    w_in_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant == CH_W'(i)) w_in_data = CH_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next_state = S_HEADER;
      S_HEADER: if (w_xfer && !w_hdr_drop)
                  w_next_state = (w_len == '0) ? S_FOOTER : S_BODY;
      S_BODY:   if (w_xfer && r_cnt == LEN_WIDTH'(1)) w_next_state = S_FOOTER;
      S_FOOTER: if (w_xfer) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    CH_READY = '0;
    if (w_slot) CH_READY[r_grant] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_grant     <= '0;
      r_rr_ptr    <= CH_W'(NUM_CH - 1);
      r_cnt       <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_m_ch      <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) r_grant <= w_pick;
      if (w_xfer) begin
        case (r_state)
          S_HEADER: if (!w_hdr_drop) r_cnt <= w_len;
          S_BODY:   r_cnt <= r_cnt - LEN_WIDTH'(1);
          S_FOOTER: begin
            r_rr_ptr    <= r_grant;
            r_frame_cnt <= r_frame_cnt + 32'd1;
          end
          default: ;
        endcase
      end
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_in_data;
        r_m_last  <= (r_state == S_FOOTER);
        r_m_ch    <= r_grant;
      end else if (M_READY) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef FRAME_STREAM_ARBITER_CHECK_EN
  logic        w_hdr_bad;
  logic        w_ftr_bad;
  logic        w_err_evt;
  logic [15:0] r_err_cnt;

  assign w_hdr_bad  = w_in_data[DATA_WIDTH-1 -: 8] != HEADER_ID;
  assign w_ftr_bad  = w_in_data[7:0] != FOOTER_ID;
  // A bad header is swallowed so the next word is tried as a header
  assign w_hdr_drop = (r_state == S_HEADER) && w_hdr_bad;
  assign w_err_evt  = w_xfer && (((r_state == S_HEADER) && (w_hdr_bad || w_len_over)) ||
                                 ((r_state == S_FOOTER) && w_ftr_bad));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                r_err_cnt <= '0;
    else if (w_err_evt && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign ERR_CNT = r_err_cnt;
`else
  logic w_unused_ids;
  assign w_unused_ids = ^{HEADER_ID, FOOTER_ID};
  assign w_hdr_drop   = 1'b0;
  assign ERR_CNT      = '0;
`endif

  assign M_VALID   = r_m_valid;
  assign M_DATA    = r_m_data;
  assign M_LAST    = r_m_last;
  assign M_CH      = r_m_ch;
  assign FRAME_CNT = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_arbiter.sv
`default_nettype none
// Bench for frame_stream_arbiter: directed scenarios plus randomized frame traffic
// checked against a frame-level round-robin order model.
module tb_frame_stream_arbiter;
  localparam int NUM_CH = 4, DW = 64, LW = 10, MAXL = 400, DEPTH = 1024;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic [NUM_CH-1:0]    CH_VALID;
  logic [NUM_CH*DW-1:0] CH_DATA;
  logic [NUM_CH-1:0]    CH_READY;
  logic                 M_VALID;
  logic [DW-1:0]        M_DATA;
  logic                 M_LAST;
  logic [1:0]           M_CH;
  logic                 M_READY;
  logic [31:0]          FRAME_CNT;
  logic [15:0]          ERR_CNT;

  frame_stream_arbiter dut (
    .CLK(CLK), .RESET(RESET), .CH_VALID(CH_VALID), .CH_DATA(CH_DATA),
    .CH_READY(CH_READY), .M_VALID(M_VALID), .M_DATA(M_DATA), .M_LAST(M_LAST),
    .M_CH(M_CH), .M_READY(M_READY), .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // per-channel source words, frame descriptors, expected and observed streams
  logic [DW-1:0] src_mem [NUM_CH][DEPTH];
  logic          src_hdr [NUM_CH][DEPTH];
  int            src_len [NUM_CH];
  int            src_pos [NUM_CH];
  int            fr_start[NUM_CH][16];
  int            fr_words[NUM_CH][16];
  int            fr_n    [NUM_CH];
  logic [DW-1:0] exp_data[$];
  int            exp_ch  [$];
  logic          exp_last[$];
  logic [DW-1:0] obs_data[$];
  int            obs_ch  [$];
  logic          obs_last[$];
  int            obs_cyc [$];
  int            exp_rr, exp_frames, exp_err;
  int            pass_cnt = 0, total_cnt = 0;
  int            proto_err, cyc = 0;
  bit            timed_out;

  task automatic push_word(input int ch, input logic [DW-1:0] w, input logic h);
    src_mem[ch][src_len[ch]] = w;
    src_hdr[ch][src_len[ch]] = h;
    src_len[ch]++;
  endtask

  task automatic add_frame(input int ch, input int len_field);
    logic [DW-1:0] r;
    logic [LW-1:0] lf;
    int nd;
    nd = (len_field > MAXL) ? MAXL : len_field;
    lf = len_field[LW-1:0];
    fr_start[ch][fr_n[ch]] = src_len[ch];
    fr_words[ch][fr_n[ch]] = nd + 2;
    fr_n[ch]++;
    r = {$urandom(), $urandom()};
    push_word(ch, {8'hFF, r[DW-9:LW], lf}, 1'b1);
    for (int i = 0; i < nd; i++) push_word(ch, {$urandom(), $urandom()}, 1'b0);
    r = {$urandom(), $urandom()};
    push_word(ch, {r[DW-1:8], 8'h0F}, 1'b0);
  endtask

  task automatic clear_sources();
    for (int c = 0; c < NUM_CH; c++) begin
      src_len[c] = 0; src_pos[c] = 0; fr_n[c] = 0;
    end
    exp_data.delete(); exp_ch.delete(); exp_last.delete();
    obs_data.delete(); obs_ch.delete(); obs_last.delete(); obs_cyc.delete();
  endtask

  // Frame-level model: whole frames, next pending channel after the last served one
  task automatic build_expected();
    int taken[NUM_CH];
    int remaining, c, k, st, nw;
    remaining = 0;
    for (int i = 0; i < NUM_CH; i++) begin taken[i] = 0; remaining += fr_n[i]; end
    while (remaining > 0) begin
      c = -1;
      for (int i = 1; i <= NUM_CH; i++) begin
        k = (exp_rr + i) % NUM_CH;
        if (c < 0 && taken[k] < fr_n[k]) c = k;
      end
      st = fr_start[c][taken[c]];
      nw = fr_words[c][taken[c]];
      for (int w = 0; w < nw; w++) begin
        exp_data.push_back(src_mem[c][st + w]);
        exp_ch.push_back(c);
        exp_last.push_back(w == nw - 1);
      end
      taken[c]++; remaining--; exp_rr = c; exp_frames++;
    end
  endtask

  // Drives sources and M_READY, records every output transfer and stall/ready anomalies
  task automatic run_traffic(input int max_cycles, input int gap_pct, input int stall_pct,
                             input int rdy_mode, input int stop_after);
    bit prev_stall, drained;
    logic [DW-1:0] hd;
    logic hl;
    logic [1:0] hc;
    prev_stall = 0; hd = '0; hl = 0; hc = '0; proto_err = 0; timed_out = 1;
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge CLK);
      drained = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (src_pos[c] < src_len[c]) begin
          drained = 0;
          CH_VALID[c] = src_hdr[c][src_pos[c]] || ($urandom_range(99) >= gap_pct);
          CH_DATA[c*DW +: DW] = src_mem[c][src_pos[c]];
        end else begin
          CH_VALID[c] = 1'b0;
          CH_DATA[c*DW +: DW] = {$urandom(), $urandom()};
        end
      end
      M_READY = (rdy_mode == 1) ? ((n % 4 == 0) || (n % 4 == 3)) : ($urandom_range(99) >= stall_pct);
      #1;
      if (drained && !M_VALID) begin timed_out = 0; break; end
      if (stop_after > 0 && obs_data.size() >= stop_after) begin timed_out = 0; break; end
      if (prev_stall && (!M_VALID || M_DATA !== hd || M_LAST !== hl || M_CH !== hc)) proto_err++;
      if ($countones(CH_READY) > 1) proto_err++;
      if (M_VALID && M_READY) begin
        obs_data.push_back(M_DATA); obs_ch.push_back(int'(M_CH));
        obs_last.push_back(M_LAST); obs_cyc.push_back(cyc);
      end
      prev_stall = M_VALID && !M_READY;
      hd = M_DATA; hl = M_LAST; hc = M_CH;
      for (int c = 0; c < NUM_CH; c++) if (CH_VALID[c] && CH_READY[c]) src_pos[c]++;
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; CH_VALID = '0; M_READY = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_rr = NUM_CH - 1; exp_frames = 0; exp_err = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; CH_VALID = '0; CH_DATA = '0; M_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    total_cnt++;
    if ({CH_READY, M_VALID, M_LAST, M_CH} !== '0)
      $display("FAIL reset_ctrl: got ready=%b valid=%b last=%b ch=%0d want all 0", CH_READY, M_VALID, M_LAST, M_CH);
    else pass_cnt++;
    total_cnt++;
    if (M_DATA !== '0) $display("FAIL reset_data: got %h want 0", M_DATA); else pass_cnt++;
    total_cnt++;
    if (FRAME_CNT !== 32'd0 || ERR_CNT !== 16'd0)
      $display("FAIL reset_counters: got frame=%0d err=%0d want 0/0", FRAME_CNT, ERR_CNT);
    else pass_cnt++;
    @(negedge CLK);
    RESET = 1'b0;
    exp_rr = NUM_CH - 1; exp_frames = 0; exp_err = 0;
  endtask

  task automatic test_frame_length();
    clear_sources();
    add_frame(0, 3);
    build_expected();
    run_traffic(200, 0, 0, 0, 0);
    total_cnt++;
    if (timed_out || obs_data.size() !== 5)
      $display("FAIL len_count: got %0d words timeout=%0b want 5", obs_data.size(), timed_out);
    else pass_cnt++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      total_cnt++;
      if (obs_data[i] !== exp_data[i] || obs_ch[i] !== 0 || obs_last[i] !== (i == 4) ||
          obs_cyc[i] - obs_cyc[0] !== i)
        $display("FAIL len_word[%0d]: got %h ch%0d last%0b dcyc%0d want %h ch0 last%0b dcyc%0d",
                 i, obs_data[i], obs_ch[i], obs_last[i], obs_cyc[i] - obs_cyc[0], exp_data[i], i == 4, i);
      else pass_cnt++;
    end
    total_cnt++;
    if (FRAME_CNT !== 32'd1) $display("FAIL len_frame_cnt: got %0d want 1", FRAME_CNT); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_sources();
    for (int k = 0; k < 2; k++) for (int c = 0; c < NUM_CH; c++) add_frame(c, 1);
    build_expected();
    run_traffic(500, 0, 0, 0, 0);
    total_cnt++;
    if (timed_out || obs_data.size() !== 24)
      $display("FAIL rr_count: got %0d words timeout=%0b want 24", obs_data.size(), timed_out);
    else pass_cnt++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      total_cnt++;
      if (obs_data[i] !== exp_data[i] || obs_ch[i] !== exp_ch[i] || obs_last[i] !== exp_last[i])
        $display("FAIL rr_word[%0d]: got %h ch%0d last%0b want %h ch%0d last%0b", i,
                 obs_data[i], obs_ch[i], obs_last[i], exp_data[i], exp_ch[i], exp_last[i]);
      else pass_cnt++;
    end
    for (int f = 0; f < 8 && 3 * f + 3 < obs_cyc.size(); f++) begin
      total_cnt++;
      if (obs_ch[3 * f] !== f % NUM_CH)
        $display("FAIL rr_order[%0d]: got ch%0d want ch%0d", f, obs_ch[3 * f], f % NUM_CH);
      else pass_cnt++;
      if (f < 7) begin
        total_cnt++;
        if (obs_cyc[3 * f + 3] - obs_cyc[3 * f + 2] !== 2)
          $display("FAIL rr_bubble[%0d]: got gap %0d want 2", f, obs_cyc[3 * f + 3] - obs_cyc[3 * f + 2]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (FRAME_CNT !== 32'd8) $display("FAIL rr_frame_cnt: got %0d want 8", FRAME_CNT); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    clear_sources();
    add_frame(1, 4);
    build_expected();
    run_traffic(300, 0, 0, 1, 0);
    total_cnt++;
    if (timed_out || obs_data.size() !== 6)
      $display("FAIL bp_count: got %0d words timeout=%0b want 6", obs_data.size(), timed_out);
    else pass_cnt++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      total_cnt++;
      if (obs_data[i] !== exp_data[i] || obs_ch[i] !== 1 || obs_last[i] !== exp_last[i])
        $display("FAIL bp_word[%0d]: got %h ch%0d last%0b want %h ch1 last%0b", i,
                 obs_data[i], obs_ch[i], obs_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (proto_err !== 0) $display("FAIL bp_stall_stable: got %0d violations want 0", proto_err); else pass_cnt++;
    total_cnt++;
    if (FRAME_CNT !== 32'(exp_frames))
      $display("FAIL bp_frame_cnt: got %0d want %0d", FRAME_CNT, exp_frames);
    else pass_cnt++;
  endtask

  task automatic test_zero_clamp();
    clear_sources();
    add_frame(2, 0);
    add_frame(2, 1000);
`ifdef FRAME_STREAM_ARBITER_CHECK_EN
    exp_err++;
`endif
    build_expected();
    run_traffic(3000, 20, 20, 0, 0);
    total_cnt++;
    if (timed_out || obs_data.size() !== 404)
      $display("FAIL clamp_count: got %0d words timeout=%0b want 404", obs_data.size(), timed_out);
    else pass_cnt++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      total_cnt++;
      if (obs_data[i] !== exp_data[i] || obs_ch[i] !== 2 || obs_last[i] !== (i == 1 || i == 403))
        $display("FAIL clamp_word[%0d]: got %h ch%0d last%0b want %h ch2 last%0b", i,
                 obs_data[i], obs_ch[i], obs_last[i], exp_data[i], (i == 1 || i == 403));
      else pass_cnt++;
    end
    total_cnt++;
    if (ERR_CNT !== exp_err[15:0]) $display("FAIL clamp_err_cnt: got %0d want %0d", ERR_CNT, exp_err); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      clear_sources();
      for (int c = 0; c < NUM_CH; c++) begin
        int nf;
        nf = $urandom_range(3, 0);
        for (int f = 0; f < nf; f++) add_frame(c, $urandom_range(6, 0));
      end
      build_expected();
      run_traffic(3000, 30, 30, 0, 0);
      total_cnt++;
      if (timed_out || obs_data.size() !== exp_data.size())
        $display("FAIL rand%0d_count: got %0d words timeout=%0b want %0d", r, obs_data.size(), timed_out, exp_data.size());
      else pass_cnt++;
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
        total_cnt++;
        if (obs_data[i] !== exp_data[i] || obs_ch[i] !== exp_ch[i] || obs_last[i] !== exp_last[i])
          $display("FAIL rand%0d_word[%0d]: got %h ch%0d last%0b want %h ch%0d last%0b", r, i,
                   obs_data[i], obs_ch[i], obs_last[i], exp_data[i], exp_ch[i], exp_last[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if (proto_err !== 0) $display("FAIL rand%0d_protocol: got %0d violations want 0", r, proto_err); else pass_cnt++;
      total_cnt++;
      if (FRAME_CNT !== 32'(exp_frames))
        $display("FAIL rand%0d_frame_cnt: got %0d want %0d", r, FRAME_CNT, exp_frames);
      else pass_cnt++;
    end
  endtask

`ifdef FRAME_STREAM_ARBITER_CHECK_EN
  task automatic test_header_check();
    logic [DW-1:0] r;
    clear_sources();
    r = {$urandom(), $urandom()};
    push_word(0, {8'hAA, r[DW-9:0]}, 1'b1);
    add_frame(0, 2);
    add_frame(0, 1);
    src_mem[0][src_len[0] - 1][7:0] = 8'h33;
    exp_err += 2;
    build_expected();
    run_traffic(300, 0, 0, 0, 0);
    total_cnt++;
    if (timed_out || obs_data.size() !== 7)
      $display("FAIL hdr_count: got %0d words timeout=%0b want 7", obs_data.size(), timed_out);
    else pass_cnt++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      total_cnt++;
      if (obs_data[i] !== exp_data[i] || obs_ch[i] !== 0 || obs_last[i] !== exp_last[i])
        $display("FAIL hdr_word[%0d]: got %h ch%0d last%0b want %h ch0 last%0b", i,
                 obs_data[i], obs_ch[i], obs_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (ERR_CNT !== exp_err[15:0]) $display("FAIL hdr_err_cnt: got %0d want %0d", ERR_CNT, exp_err); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid();
    clear_sources();
    add_frame(0, 5);
    build_expected();
    run_traffic(200, 0, 0, 0, 3);
    #2 RESET = 1'b1;
    #1;
    total_cnt++;
    if (timed_out || M_VALID !== 1'b0 || CH_READY !== '0 || FRAME_CNT !== 32'd0)
      $display("FAIL rstmid_async: got valid=%b ready=%b frame=%0d timeout=%0b want 0/0/0/0",
               M_VALID, CH_READY, FRAME_CNT, timed_out);
    else pass_cnt++;
    @(negedge CLK);
    RESET = 1'b0; CH_VALID = '0;
    exp_rr = NUM_CH - 1; exp_frames = 0; exp_err = 0;
    clear_sources();
    add_frame(2, 3);
    build_expected();
    run_traffic(200, 10, 10, 0, 0);
    total_cnt++;
    if (timed_out || obs_data.size() !== 5)
      $display("FAIL rstmid_count: got %0d words timeout=%0b want 5", obs_data.size(), timed_out);
    else pass_cnt++;
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
      total_cnt++;
      if (obs_data[i] !== exp_data[i] || obs_ch[i] !== 2 || obs_last[i] !== (i == 4))
        $display("FAIL rstmid_word[%0d]: got %h ch%0d last%0b want %h ch2 last%0b", i,
                 obs_data[i], obs_ch[i], obs_last[i], exp_data[i], i == 4);
      else pass_cnt++;
    end
    total_cnt++;
    if (FRAME_CNT !== 32'd1) $display("FAIL rstmid_frame_cnt: got %0d want 1", FRAME_CNT); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frame_length();
    test_round_robin();
    test_backpressure();
    test_zero_clamp();
    test_random();
`ifdef FRAME_STREAM_ARBITER_CHECK_EN
    test_header_check();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
